instr_fetch: RTL and testbench

Instruction fetch and PC-sequencing stage of the simple MIPS core, directly upstream of the main opcode decoder. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds the fetched instruction stable while the decoder and datapath consume it. When the instruction retires, it selects the next PC from the decoder's Jump, Branch and Bne outputs and the ALU zero flag.

---
 rtl/imem_if.sv | 13 +
 rtl/instr_fetch.sv | 76 +++++++
 tb/tb_instr_fetch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/imem_if.sv
// imem_if: instruction memory read handshake between fetch stage and memory.
//   req   - read request (master -> slave)
//   addr  - byte address of the request (master -> slave)
//   ack   - read data valid (slave -> master)
//   rdata - instruction word, valid with ack (slave -> master)
interface imem_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC sequencing and instruction fetch stage feeding the decoder.
//   clk, rst          - clock, synchronous active-high reset
//   imem              - imem_if master: req/addr out, ack/rdata in
//   stall             - datapath cannot retire the held instruction
//   jump/branch/bne   - decoder control outputs for the held instruction
//   zero              - ALU zero flag for the held instruction
//   instr, opcode     - held instruction word and its opcode field
//   pc, pc_plus4      - address of held/in-flight instruction and pc + 4
//   instr_valid       - instr holds an unretired fetched instruction
//   retire_cnt        - retired instruction count (only with IFETCH_RETIRE_CNT_EN)
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    imem_if.master      imem,
    input  logic        stall,
    input  logic        jump,
    input  logic        branch,
    input  logic        bne,
    input  logic        zero,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
`ifdef IFETCH_RETIRE_CNT_EN
    output logic [31:0] retire_cnt,
`endif
    output logic        instr_valid
);
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]  state;
    logic [31:0] next_pc;
    logic        taken;
    logic        retire;

    assign imem.req    = state == FETCH;
    assign imem.addr   = pc;
    assign instr_valid = state == HOLD;
    assign opcode      = instr[31:26];
    assign pc_plus4    = pc + 32'd4;
    assign taken       = (branch & zero) | (bne & ~zero);
    assign retire      = state == HOLD && !stall;

    always_comb
        next_pc = jump  ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                  taken ? pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00} :
                          pc_plus4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            instr <= 32'h0;
        end else if (state == FETCH) begin
            if (imem.ack) begin
                instr <= imem.rdata;
                state <= HOLD;
            end
        end else if (retire) begin
            pc    <= next_pc;
            state <= FETCH;
        end
    end

`ifdef IFETCH_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            retire_cnt <= 32'h0;
        else if (retire)
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed check of instr_fetch against a PC-rule model.
module tb_instr_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, jump = 1'b0, branch = 1'b0, bne = 1'b0, zero = 1'b0;
    logic [31:0] instr, pc, pc_plus4;
    logic [5:0]  opcode;
    logic        instr_valid;
`ifdef IFETCH_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pc;
    int unsigned exp_cnt;

    imem_if bus ();

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .imem(bus), .stall(stall), .jump(jump),
        .branch(branch), .bne(bne), .zero(zero), .instr(instr), .opcode(opcode),
        .pc(pc), .pc_plus4(pc_plus4),
`ifdef IFETCH_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input bit j, input bit b, input bit n, input bit z);
        logic [31:0] s;
        s = p + 32'd4;
        if (j) return (s & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
        if ((b && z) || (n && !z)) return s + 32'(int'($signed(w[15:0])) * 4);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ctrl();
        jump = 1'($urandom); branch = 1'($urandom); bne = 1'($urandom); zero = 1'($urandom);
    endtask

    task automatic chk_cnt();
`ifdef IFETCH_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, exp_cnt);
`endif
    endtask

    // One full instruction: fetch with ack delay, hold with stalls, retire with given controls.
    task automatic run_instr(input logic [31:0] w, input int dly, input int stalls,
                             input bit j, input bit b, input bit n, input bit z);
        chk("fetch_req", {31'b0, bus.req}, 32'd1);
        chk("fetch_addr", bus.addr, exp_pc);
        chk("fetch_valid", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < dly; i++) begin
            bus.ack = 1'b0;
            bus.rdata = $urandom;
            stall = 1'($urandom);
            rand_ctrl();
            step();
            chk("wait_addr", bus.addr, exp_pc);
            chk("wait_valid", {31'b0, instr_valid}, 32'd0);
        end
        bus.ack = 1'b1;
        bus.rdata = w;
        stall = 1'($urandom);
        rand_ctrl();
        step();
        bus.ack = 1'b0;
        bus.rdata = $urandom;
        chk("hold_valid", {31'b0, instr_valid}, 32'd1);
        chk("hold_req", {31'b0, bus.req}, 32'd0);
        chk("hold_instr", instr, w);
        chk("hold_opcode", {26'b0, opcode}, {26'b0, w[31:26]});
        chk("hold_pc", pc, exp_pc);
        chk("hold_pc4", pc_plus4, exp_pc + 32'd4);
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            bus.ack = 1'($urandom);
            rand_ctrl();
            step();
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_instr", instr, w);
            chk("stall_pc", pc, exp_pc);
            chk_cnt();
        end
        bus.ack = 1'b0;
        stall = 1'b0;
        jump = j; branch = b; bne = n; zero = z;
        step();
        exp_pc = model_next(exp_pc, w, j, b, n, z);
        exp_cnt++;
        chk("retire_pc", pc, exp_pc);
        chk_cnt();
    endtask

    initial begin
        bus.ack = 1'b1;
        bus.rdata = 32'hDEAD_BEEF;
        exp_cnt = 0;
        exp_pc = RST_PC;
        step();
        step();
        rst = 1'b0;
        bus.ack = 1'b0;
        #0;
        chk("rst_req", {31'b0, bus.req}, 32'd1);
        chk("rst_addr", bus.addr, RST_PC);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk_cnt();

        run_instr(32'h2000_0001, 0, 0, 0, 0, 0, 0);
        chk("seq_44", exp_pc, 32'h44);
        run_instr(32'h2000_0002, 3, 2, 0, 0, 0, 0);
        run_instr(32'h0800_0040, 0, 1, 1, 0, 0, 0);
        chk("jump_100", bus.addr, 32'h100);
        run_instr(32'h1000_FFFE, 1, 0, 0, 1, 0, 1);
        chk("beq_taken", bus.addr, 32'h0FC);
        run_instr(32'h2000_0003, 0, 0, 0, 0, 0, 0);
        run_instr(32'h1000_FFFE, 0, 0, 0, 1, 0, 0);
        chk("beq_not_taken", bus.addr, 32'h104);
        run_instr(32'h0800_0080, 0, 0, 1, 0, 0, 0);
        run_instr(32'h1400_0003, 2, 1, 0, 0, 1, 0);
        chk("bne_taken", bus.addr, 32'h210);
        run_instr(32'h1000_FF7A, 0, 0, 0, 1, 0, 1);
        chk("branch_to_top", bus.addr, 32'hFFFF_FFFC);
        run_instr(32'h2000_0004, 0, 2, 0, 0, 0, 0);
        chk("wrap_zero", bus.addr, 32'h0);

        for (int k = 0; k < 60; k++)
            run_instr($urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        rst = 1'b1;
        bus.ack = 1'b1;
        bus.rdata = 32'h1234_5678;
        step();
        rst = 1'b0;
        bus.ack = 1'b0;
        exp_pc = RST_PC;
        exp_cnt = 0;
        chk("rst_ack_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_ack_addr", bus.addr, RST_PC);
        chk("rst_ack_instr", instr, 32'h0);
        chk_cnt();
        step();
        chk("rst_ack_still_fetch", {31'b0, instr_valid}, 32'd0);
        run_instr(32'h2000_0005, 1, 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
